// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Stall/flush controller for a 5-stage pipeline with saturating
//           stall/flush debug counters and a halt state.
// Rev     : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_DataRead,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_DataRead,
  input  logic             exmem_DataWrite,
  input  logic             exmem_redirect,
  input  logic             exmem_Halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [2:0]       stall_code,
  output logic             halt,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  pipe_stall_t      code;
  logic             mem_pend;
  logic             load_use;
  logic             redirect_taken;

  assign mem_pend = (exmem_DataRead | exmem_DataWrite) & ~dhit;
  assign load_use = idex_DataRead & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    memwb_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    code           = NO_STALL;
    redirect_taken = 1'b0;
    state_d        = state_q;

    if (state_q == HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      code = FULL_STALL;
    end else if (mem_pend) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      code    = FULL_STALL;
      state_d = MEMWAIT;
    end else begin
      // MEMWAIT releases in the dhit cycle, which is then evaluated as RUN
      state_d = RUN;
      if (exmem_Halt) begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        code        = EXMEM_STALL;
        state_d     = HALTED;
      end else if (exmem_redirect) begin
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        exmem_flush    = 1'b1;
        redirect_taken = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        code       = IDEX_STALL;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        code       = IFID_STALL;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if ((code != NO_STALL) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
    if (redirect_taken && (flush_count_q != {CNT_W{1'b1}}))
      flush_count_d = flush_count_q + 1'b1;
  end

  assign stall_code  = code;
  assign halt        = (state_q == HALTED);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire
